aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Round sequencer for the AES cipher datapath. Accepts one block per valid/ready handshake and drives the per-cycle controls of the state registers (`sa*` load/advance through SubBytes/ShiftRows/MixColumns) and of the key expansion unit. Counts rounds, asserts the final-round MixColumns bypass, and holds the result until downstream accepts it. Sits between the block-level handshake and the `aes_cipher_top`-style datapath; it contains no datapath logic itself.

## Interface
- `NR`, default 10: number of cipher rounds; legal values 10, 12, 14 (AES-128/192/256).
- `RW`, default 4: width of the round counter; must satisfy 2^RW > NR.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `in_valid`  in  1  new plaintext and key present on the datapath inputs.
- `in_ready`  out  1  controller idle and able to accept.
- `kexp_ready`  in  1  key expansion has the next round key available.
- `out_ready`  in  1  downstream accepts the result.
- `out_valid`  out  1  `text_out` register holds a finished block.
- `sa_load`  out  1  load `text_in ^ key` into the state registers.
- `sa_round_en`  out  1  advance the state registers by one round.
- `last_round`  out  1  bypass MixColumns this cycle.
- `kexp_start`  out  1  restart key expansion from the cipher key.
- `kexp_en`  out  1  advance key expansion by one round key.
- `round`  out  RW  current round index, 0..NR.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, ROUND, FINAL, DONE. All outputs are decoded from the state register and `round`, gated by `kexp_ready` where stated. There are no combinational paths from `in_valid` or `out_ready`.
- IDLE:
  - `in_ready`=1.
  - If `in_valid` is high, go to LOAD.
- LOAD:
  - `sa_load`=1, `kexp_start`=1, `round`=0.
  - Unconditionally go to ROUND with `round`=1.
- ROUND (`round` 1..NR-1):
  - If `kexp_ready`=1: `sa_round_en`=1 and `kexp_en`=1, then `round` increments. When `round`==NR-1, go to FINAL with `round`=NR.
  - If `kexp_ready`=0: stall. `sa_round_en`=0, `kexp_en`=0, state and `round` hold.
- FINAL (`round`=NR):
  - `last_round`=1.
  - If `kexp_ready`=1: `sa_round_en`=1 and `kexp_en`=1, then go to DONE.
  - If `kexp_ready`=0: `last_round` stays 1 while `sa_round_en`=0 and `kexp_en`=0; hold.
- DONE:
  - `out_valid`=1, `round` holds NR.
  - If `out_ready`=1, go to IDLE and clear `round` to 0.
  - If `out_ready`=0, hold indefinitely.
- `in_valid` is ignored outside IDLE; there is no queuing.
- `round` arithmetic: unsigned, RW bits. Never exceeds NR and never wraps.
- `sa_round_en` is high in exactly NR cycles per block. `kexp_en` pulses equal `sa_round_en` pulses.
- Reset:
  - While `rst`=1, all outputs are 0, including `in_ready`.
  - On the first cycle after `rst` deasserts: state=IDLE, `round`=0, `in_ready`=1, all other outputs 0.
  - Reset in any state aborts the block with no `out_valid`; the partially processed state is discarded.

## Timing
- Accept at edge E (IDLE with `in_valid`=1). LOAD occupies cycle E+1. Rounds 1..NR occupy cycles E+2..E+NR+1. `out_valid` rises in cycle E+NR+2.
- Latency from accept to `out_valid` is NR+2 cycles with no stalls. Each `kexp_ready`=0 cycle adds exactly one cycle.
- Minimum block period is NR+3 cycles (IDLE, LOAD, NR rounds, DONE) with `in_valid` and `out_ready` both held high.
- Handshakes complete on a clock edge where valid and ready are both high. `out_valid` is stable until it is accepted.
- `in_ready` and `out_valid` are never high in the same cycle.

## Test plan
- Single block, NR=10, `kexp_ready`=1, `out_ready`=1: `in_valid` seen at edge 0 → `sa_load` in cycle 1; `sa_round_en` in cycles 2–11; `last_round` only in cycle 11; `out_valid` for one cycle at cycle 12; `in_ready` high again at cycle 13.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` rises → `out_valid` held 6 cycles, `round`=10 throughout; returns to IDLE one cycle after `out_ready`=1.
- Key stall: `kexp_ready`=0 for 3 cycles in round 4 and 2 cycles in FINAL → `round` frozen at 4 and then at 10; `sa_round_en` count stays exactly 10; `out_valid` arrives at cycle 17.
- Reset in ROUND with `round`=6: `rst` high for 1 cycle → all outputs 0 during reset; next cycle IDLE with `in_ready`=1 and `round`=0; no `out_valid` ever produced for the aborted block.
- `in_valid` held high continuously with `out_ready`=1 → one block accepted every 13 cycles; `in_valid` ignored while `busy`=1.
- NR=14, RW=4 → 14 `sa_round_en` pulses; `last_round` in round 14 only; `out_valid` 16 cycles after accept.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an AES cipher datapath: accepts a block, steps the state
// registers and key expansion through NR rounds, and holds the result until accepted.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          kexp_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          sa_load,
  output logic          sa_round_en,
  output logic          last_round,
  output logic          kexp_start,
  output logic          kexp_en,
  output logic [RW-1:0] round,
  output logic          busy,
  output logic [2:0]    state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; out_valid holds steady until accepted, in_ready only while IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [RW-1:0] ROUND_ONE = RW'(1);
  localparam logic [RW-1:0] ROUND_PRE = RW'(NR - 1);

  state_t        state;
  logic [RW-1:0] round_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      round_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) state <= LOAD;
        end
        LOAD: begin
          state   <= ROUND;
          round_q <= ROUND_ONE;
        end
        ROUND: begin
          if (kexp_ready) begin
            round_q <= round_q + ROUND_ONE;
            if (round_q == ROUND_PRE) state <= FINAL;
          end
        end
        FINAL: begin
          if (kexp_ready) state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state   <= IDLE;
            round_q <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          round_q <= '0;
        end
      endcase
    end
  end

  // Reset forces every output low in the same cycle, so decode is gated by rst.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    sa_load     = 1'b0;
    sa_round_en = 1'b0;
    last_round  = 1'b0;
    kexp_start  = 1'b0;
    kexp_en     = 1'b0;
    busy        = 1'b0;
    round       = '0;
    if (!rst) begin
      round = round_q;
      busy  = (state != IDLE);
      case (state)
        IDLE:  in_ready = 1'b1;
        LOAD: begin
          sa_load    = 1'b1;
          kexp_start = 1'b1;
        end
        ROUND: begin
          sa_round_en = kexp_ready;
          kexp_en     = kexp_ready;
        end
        FINAL: begin
          last_round  = 1'b1;
          sa_round_en = kexp_ready;
          kexp_en     = kexp_ready;
        end
        DONE:  out_valid = 1'b1;
        default: busy = 1'b0;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: directed cycle tables, a randomized run against a
// round-counting reference model, and an NR=14 latency sequence.
module tb_aes_round_ctrl;

  localparam int NR10 = 10;
  localparam int NR14 = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_valid14 = 1'b0;
  logic       kexp_ready = 1'b1;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, sa_load, sa_round_en, last_round, kexp_start, kexp_en, busy;
  logic [3:0] round;
  logic [2:0] state_dbg;
  logic       in_ready14, out_valid14, sa_load14, sa_round_en14, last_round14;
  logic       kexp_start14, kexp_en14, busy14;
  logic [3:0] round14;
  logic [2:0] state_dbg14;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR10), .RW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .kexp_ready(kexp_ready), .out_ready(out_ready), .out_valid(out_valid),
    .sa_load(sa_load), .sa_round_en(sa_round_en), .last_round(last_round),
    .kexp_start(kexp_start), .kexp_en(kexp_en), .round(round), .busy(busy),
    .state_dbg(state_dbg)
  );

  aes_round_ctrl #(.NR(NR14), .RW(4)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14),
    .kexp_ready(kexp_ready), .out_ready(out_ready), .out_valid(out_valid14),
    .sa_load(sa_load14), .sa_round_en(sa_round_en14), .last_round(last_round14),
    .kexp_start(kexp_start14), .kexp_en(kexp_en14), .round(round14), .busy(busy14),
    .state_dbg(state_dbg14)
  );

  typedef struct {
    logic       r;
    logic       iv;
    logic       kr;
    logic       ordy;
    logic [11:0] e;
  } vec_t;

  vec_t        tbl[$];
  logic [11:0] exp_q[$];

  function automatic logic [11:0] ex(input logic ir, ov, ld, re, lr, ks, ke, bz, input int rnd);
    logic [3:0] r4;
    r4 = 4'(rnd);
    return {ir, ov, ld, re, lr, ks, ke, bz, r4};
  endfunction

  function automatic logic [11:0] act10();
    return {in_ready, out_valid, sa_load, sa_round_en, last_round, kexp_start, kexp_en, busy, round};
  endfunction

  task automatic check(input string name, input int idx, input logic [11:0] act, input logic [11:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, expv);
    end
  endtask

  task automatic add(input logic r, iv, kr, ordy, input logic [11:0] e);
    vec_t v;
    v.r = r; v.iv = iv; v.kr = kr; v.ordy = ordy; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic add_idle(input logic iv);
    add(1'b0, iv, 1'b1, 1'b1, ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // One unstalled block from the accept cycle through the accepting DONE cycle.
  task automatic add_block(input logic iv_hold, input int bp_cycles);
    add_idle(1'b1);
    add(1'b0, iv_hold, 1'b1, 1'b1, ex(0, 0, 1, 0, 0, 1, 0, 1, 0));
    for (int r = 1; r < NR10; r++) add(1'b0, iv_hold, 1'b1, 1'b1, ex(0, 0, 0, 1, 0, 0, 1, 1, r));
    add(1'b0, iv_hold, 1'b1, 1'b1, ex(0, 0, 0, 1, 1, 0, 1, 1, NR10));
    for (int b = 0; b < bp_cycles; b++) add(1'b0, iv_hold, 1'b1, 1'b0, ex(0, 1, 0, 0, 0, 0, 0, 1, NR10));
    add(1'b0, iv_hold, 1'b1, 1'b1, ex(0, 1, 0, 0, 0, 0, 0, 1, NR10));
  endtask

  task automatic build_table();
    add(1'b1, 1'b0, 1'b1, 1'b1, 12'h000);
    add_idle(1'b0);
    add_block(1'b0, 0);
    add_idle(1'b0);
    add_block(1'b0, 5);
    add_idle(1'b0);
    // Key stall: three cycles in round 4, two in FINAL.
    add_idle(1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 1, 0, 0, 1, 0, 1, 0));
    for (int r = 1; r <= 3; r++) add(1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 1, 0, 0, 1, 1, r));
    for (int s = 0; s < 3; s++) add(1'b0, 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, 0, 0, 1, 4));
    for (int r = 4; r <= 9; r++) add(1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 1, 0, 0, 1, 1, r));
    for (int s = 0; s < 2; s++) add(1'b0, 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 1, 0, 0, 1, 10));
    add(1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 1, 1, 0, 1, 1, 10));
    add(1'b0, 1'b0, 1'b1, 1'b1, ex(0, 1, 0, 0, 0, 0, 0, 1, 10));
    add_idle(1'b0);
    // Reset while round 6 is current.
    add_idle(1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 1, 0, 0, 1, 0, 1, 0));
    for (int r = 1; r <= 5; r++) add(1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 1, 0, 0, 1, 1, r));
    add(1'b1, 1'b0, 1'b1, 1'b1, 12'h000);
    for (int i = 0; i < 4; i++) add_idle(1'b0);
    // in_valid held high: a new block every 13 cycles.
    add_block(1'b1, 0);
    add_block(1'b1, 0);
    add_idle(1'b0);
  endtask

  // Reference model: tracks whether a block is held, whether it has been
  // loaded, and how many rounds have completed.
  bit m_active, m_loaded;
  int m_rd;
  int obs_pulses;

  function automatic logic [11:0] model_out(input logic r, input logic kr);
    int cur;
    logic run;
    if (r) return 12'h000;
    if (!m_active) return ex(1, 0, 0, 0, 0, 0, 0, 0, 0);
    if (!m_loaded) return ex(0, 0, 1, 0, 0, 1, 0, 1, 0);
    if (m_rd >= NR10) return ex(0, 1, 0, 0, 0, 0, 0, 1, NR10);
    cur = m_rd + 1;
    run = kr;
    return ex(0, 0, 0, run, (cur == NR10), 0, run, 1, cur);
  endfunction

  task automatic model_step(input logic r, iv, kr, ordy);
    if (r) begin
      m_active = 0; m_loaded = 0; m_rd = 0;
    end else if (!m_active) begin
      if (iv) begin
        m_active = 1; m_loaded = 0; m_rd = 0;
        exp_q.push_back(12'(NR10));
      end
    end else if (!m_loaded) begin
      m_loaded = 1;
    end else if (m_rd < NR10) begin
      if (kr) m_rd++;
    end else if (ordy) begin
      m_active = 0;
    end
  endtask

  initial begin
    int ov_cyc, pulses14, lr_cnt;
    logic [3:0] lr_round;

    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r; in_valid = tbl[i].iv; kexp_ready = tbl[i].kr; out_ready = tbl[i].ordy;
      #1;
      check("vec", i, act10(), tbl[i].e);
    end

    m_active = 0; m_loaded = 0; m_rd = 0; obs_pulses = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 79) == 0);
      in_valid   = $urandom_range(0, 1);
      kexp_ready = ($urandom_range(0, 3) != 0);
      out_ready  = $urandom_range(0, 1);
      #1;
      check("rand", c, act10(), model_out(rst, kexp_ready));
      if (rst) begin
        exp_q.delete();
        obs_pulses = 0;
      end else begin
        if (sa_load) obs_pulses = 0;
        if (sa_round_en) obs_pulses++;
        if (out_valid && out_ready) begin
          if (exp_q.size() > 0) check("pulses", c, 12'(obs_pulses), exp_q.pop_front());
          else check("unexpected_out", c, 12'h001, 12'h000);
        end
      end
      model_step(rst, in_valid, kexp_ready, out_ready);
    end

    @(negedge clk);
    rst = 1; in_valid = 0; kexp_ready = 1; out_ready = 1;
    @(negedge clk);
    rst = 0; in_valid14 = 1;
    #1;
    check("nr14_ready", 0, {11'd0, in_ready14}, 12'h001);
    ov_cyc = -1; pulses14 = 0; lr_cnt = 0; lr_round = 4'd0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      in_valid14 = 0;
      #1;
      if (sa_round_en14) pulses14++;
      if (last_round14) begin
        lr_cnt++;
        lr_round = round14;
      end
      if (out_valid14) begin
        ov_cyc = c;
        break;
      end
    end
    check("nr14_latency", 0, 12'(ov_cyc), 12'd16);
    check("nr14_pulses", 0, 12'(pulses14), 12'd14);
    check("nr14_last_cnt", 0, 12'(lr_cnt), 12'd1);
    check("nr14_last_round", 0, {8'd0, lr_round}, 12'd14);
    @(negedge clk);
    #1;
    check("nr14_idle", 0, {11'd0, in_ready14}, 12'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
